// File: rtl/ins_mem_loader.sv
// Instruction BRAM loader: frames a little-endian word count plus payload from a byte stream
// and writes full words through BRAM port A. Optional trailing checksum: INS_MEM_LOADER_CKSUM_EN.
module ins_mem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err,
    output logic        ins_mem_clka,
    output logic        ins_mem_ena,
    output logic        ins_mem_rsta,
    output logic [3:0]  ins_mem_wea,
    output logic [31:0] ins_mem_addra,
    output logic [31:0] ins_mem_dina,
    input  logic        ins_mem_rsta_busy
);

`ifdef INS_MEM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN = 3'd1, S_DATA = 3'd2, S_WRITE = 3'd3,
        S_DONE = 3'd4, S_ERR = 3'd5, S_CKSUM = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN = 3'd1, S_DATA = 3'd2, S_WRITE = 3'd3,
        S_DONE = 3'd4, S_ERR = 3'd5
    } state_t;
`endif

    state_t      state, state_n;
    logic [1:0]  byte_cnt;
    logic [31:0] len;
    logic [31:0] word_idx;
    logic [31:0] len_nx;
    logic        accept;
    logic        last_byte;
    logic        start;
    logic        hold_n;
`ifdef INS_MEM_LOADER_CKSUM_EN
    logic [31:0] sum;
    logic [31:0] cksum;
    logic [31:0] cksum_nx;
`endif

    assign ins_mem_clka = clk;
    assign ins_mem_rsta = 1'b0;

`ifdef INS_MEM_LOADER_CKSUM_EN
    assign s_ready  = (state == S_LEN || state == S_DATA || state == S_CKSUM) && !ins_mem_rsta_busy;
    assign cksum_nx = {s_data, cksum[31:8]};
`else
    assign s_ready  = (state == S_LEN || state == S_DATA) && !ins_mem_rsta_busy;
`endif
    assign accept    = s_valid && s_ready;
    assign last_byte = accept && (byte_cnt == 2'd3);
    assign len_nx    = {s_data, len[31:8]};
    assign start     = load_start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        hold_n  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_n = S_LEN;
            S_LEN: begin
                if (last_byte)
                    state_n = (len_nx == 32'd0 || len_nx > 32'(DEPTH_WORDS)) ? S_ERR : S_DATA;
            end
            S_DATA: if (last_byte) state_n = S_WRITE;
            S_WRITE: begin
`ifdef INS_MEM_LOADER_CKSUM_EN
                state_n = (word_idx + 32'd1 == len) ? S_CKSUM : S_DATA;
`else
                state_n = (word_idx + 32'd1 == len) ? S_DONE : S_DATA;
`endif
            end
`ifdef INS_MEM_LOADER_CKSUM_EN
            S_CKSUM: if (last_byte) state_n = (cksum_nx == sum) ? S_DONE : S_ERR;
`endif
            default: state_n = S_IDLE;
        endcase
        case (state_n)
            S_LEN, S_DATA, S_WRITE: hold_n = 1'b1;
`ifdef INS_MEM_LOADER_CKSUM_EN
            S_CKSUM:                hold_n = 1'b1;
`endif
            default:                hold_n = 1'b0;
        endcase
    end

    // Registered outputs and framing datapath; the write-data register doubles as the byte shifter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_hold     <= 1'b0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            ins_mem_ena   <= 1'b0;
            ins_mem_wea   <= 4'h0;
            ins_mem_addra <= BASE_ADDR;
            ins_mem_dina  <= 32'd0;
            byte_cnt      <= 2'd0;
            len           <= 32'd0;
            word_idx      <= 32'd0;
`ifdef INS_MEM_LOADER_CKSUM_EN
            sum           <= 32'd0;
            cksum         <= 32'd0;
`endif
        end else begin
            core_hold   <= hold_n;
            load_done   <= (state_n == S_DONE) && (state != S_DONE);
            load_err    <= (state_n == S_ERR);
            ins_mem_ena <= (state_n == S_WRITE);
            ins_mem_wea <= (state_n == S_WRITE) ? 4'hF : 4'h0;
            if (start) begin
                byte_cnt      <= 2'd0;
                word_idx      <= 32'd0;
                ins_mem_addra <= BASE_ADDR;
`ifdef INS_MEM_LOADER_CKSUM_EN
                sum           <= 32'd0;
`endif
            end else begin
                if (accept) byte_cnt <= byte_cnt + 2'd1;
                if (accept && state == S_LEN)  len <= len_nx;
                if (accept && state == S_DATA) ins_mem_dina <= {s_data, ins_mem_dina[31:8]};
`ifdef INS_MEM_LOADER_CKSUM_EN
                if (accept && state == S_CKSUM) cksum <= cksum_nx;
`endif
                if (state == S_WRITE) begin
                    word_idx      <= word_idx + 32'd1;
                    ins_mem_addra <= ins_mem_addra + 32'd4;
`ifdef INS_MEM_LOADER_CKSUM_EN
                    sum           <= sum + ins_mem_dina;
`endif
                end
            end
        end
    end

endmodule

// File: doc/ins_mem_loader.md
# ins_mem_loader

Program loader that fills the instruction BRAM through its write port from an 8-bit byte stream (e.g. the debug UART receiver) while holding the core off. It is the writer at the opposite end of the instruction-memory BRAM interface whose port B the fetch stage only reads. It frames a little-endian word count plus payload and issues one 32-bit full-word write per assembled instruction. It reports completion or error to the boot/control logic.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- DEPTH_WORDS, 4096: BRAM capacity in words; larger counts are rejected.
- clk  in  1  system clock; also forwarded as ins_mem_clka.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse; starts a load from IDLE, DONE or ERR; ignored in other states.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  byte-stream data.
- s_ready  out  1  byte accepted when s_valid && s_ready at a rising edge.
- core_hold  out  1  high from the start of a load until DONE or ERR; drives the core's reset/stall.
- load_done  out  1  one-cycle pulse on successful completion.
- load_err  out  1  level; high in ERR until the next load_start.
- ins_mem_clka  out  1  = clk.
- ins_mem_ena  out  1  high only on the write cycle.
- ins_mem_rsta  out  1  tied 0.
- ins_mem_wea  out  4  4'hF on the write cycle, else 0.
- ins_mem_addra  out  32  byte address BASE_ADDR + 4*word_idx.
- ins_mem_dina  out  32  assembled word.
- ins_mem_rsta_busy  in  1  BRAM reset busy; stalls the stream while high.

## Operation
- States: IDLE, LEN, DATA, WRITE, CKSUM (macro only), DONE, ERR.
- IDLE --load_start--> LEN. Clears word_idx, byte_cnt and sum, and raises core_hold.
- LEN: accepts 4 bytes, LSB first, into len.
  - If len == 0 or len > DEPTH_WORDS, go to ERR.
  - Otherwise go to DATA.
- DATA: accepts bytes LSB first into a shift register. On the 4th byte go to WRITE.
- WRITE (one cycle):
  - Outputs ena=1, wea=4'hF, addra, dina.
  - Adds the word to sum (mod 2^32) and increments word_idx.
  - If word_idx+1 == len, go to CKSUM, or to DONE when the macro is off. Otherwise go to DATA.
- DONE: pulses load_done for one cycle, drops core_hold, and remains in DONE.
- ERR: holds load_err=1 and drops core_hold.
- s_ready = (state is LEN, DATA or CKSUM) && !ins_mem_rsta_busy.
- A load_start arriving mid-load (LEN, DATA, WRITE, CKSUM) is ignored.
- byte_cnt is 2 bits and wraps 3→0. word_idx is 32 bits and never exceeds len.

## Timing
- Reset values: s_ready=0, core_hold=0, load_done=0, load_err=0, ena=0, wea=0, addra=BASE_ADDR, dina=0, state=IDLE.
- An asynchronous reset assertion mid-load returns to IDLE immediately. The BRAM contents are then partial, and no load_done is produced.
- core_hold rises in the cycle after the load_start edge.
- The write occurs in the cycle immediately after the edge on which the 4th byte of a word is accepted. s_ready is 0 during that WRITE cycle.
- Sustained throughput is one word per 5 cycles with s_valid held high.
- load_done is asserted in the cycle after the last WRITE (no checksum) or after the last CKSUM byte. core_hold falls in that same cycle.

## Configuration
- INS_MEM_LOADER_CKSUM_EN defined:
  - After the payload, CKSUM accepts 4 bytes, LSB first.
  - If the value equals the mod-2^32 sum of the written words, go to DONE; otherwise go to ERR.
  - The words are already written on mismatch; ERR signals that the image is invalid.
- INS_MEM_LOADER_CKSUM_EN undefined:
  - There is no CKSUM state and no sum register.
  - The load ends after the last WRITE.

## Test plan
- len=2, words 0x00000013 and 0x00100093 with s_valid held high -> 2 writes: addra 0x0 then 0x4, wea=F, dina matching; load_done 1 cycle after the 2nd write; core_hold high throughout the load.
- len=0 -> ERR after the 4th length byte; load_err=1, no writes, core_hold=0.
- len=DEPTH_WORDS+1 -> ERR; len=DEPTH_WORDS -> accepted, last addra = BASE_ADDR+4*(DEPTH_WORDS-1).
- s_valid toggled randomly and ins_mem_rsta_busy pulsed high for 3 cycles mid-word -> s_ready=0 during busy; write data is unchanged.
- load_start repeated mid-load -> ignored. Reset asserted after 1 of 3 words -> outputs return to reset values immediately; a new load then succeeds.
- With the macro: correct checksum -> load_done; checksum off by 1 -> load_err=1 and no load_done.
